// File: rtl/ram_burst_model.sv
// rtl/ram_burst_model.sv - behavioural line RAM with burst beats, access latency and backdoor line view
// Define RAM_MODEL_CHECK_EN to flag (and report) ram_avalid asserted while a transfer is in flight.
module ram_burst_model #(
  parameter int ADDR_SIZE  = 13,
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WIDTH = 64,
  parameter int LATENCY    = 5
) (
  input  logic                  ram_clk,
  input  logic                  ram_rst_n,
  input  logic [ADDR_SIZE-1:0]  ram_addr,
  input  logic                  ram_avalid,
  input  logic                  ram_rnw,
  input  logic [WORD_SIZE-1:0]  ram_wdata,
  output logic [WORD_SIZE-1:0]  ram_rdata,
  output logic                  ram_ack,
  output logic [LINE_WIDTH-1:0] data_backdoor,
  output logic                  proto_err
);
  localparam int BEATS = LINE_WIDTH / WORD_SIZE;
  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int PW    = ADDR_SIZE + BW + 1;

  typedef enum logic [2:0] {IDLE, WR_BEATS, WAIT, RD_BEATS, WR_ACK} state_t;

  state_t                state, state_nx;
  logic [LW-1:0]         lat_cnt, lat_cnt_nx;
  logic [BW-1:0]         beat, beat_nx;
  logic [ADDR_SIZE-1:0]  addr_q;
  logic                  is_read;
  logic [LINE_WIDTH-1:0] wbuf, wline, pattern, cur_line;
  logic [LINE_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      written;
  logic                  accept, commit, last_beat, lat_done;

  assign accept    = (state == IDLE) && ram_avalid;
  assign last_beat = (beat == BW'(BEATS - 1));
  assign lat_done  = (lat_cnt == LW'(LATENCY - 1));
  assign commit    = (state == WR_BEATS) && last_beat;

  always_ff @(posedge ram_clk or negedge ram_rst_n) begin
    if (!ram_rst_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
      beat    <= '0;
      addr_q  <= '0;
      is_read <= 1'b0;
      written <= '0;
    end else begin
      state   <= state_nx;
      lat_cnt <= lat_cnt_nx;
      beat    <= beat_nx;
      if (accept) begin
        addr_q  <= ram_addr;
        is_read <= ram_rnw;
      end
      if (commit) written[addr_q] <= 1'b1;
    end
  end

  always_comb begin
    state_nx   = state;
    lat_cnt_nx = lat_cnt;
    beat_nx    = beat;
    case (state)
      IDLE: begin
        if (ram_avalid) begin
          state_nx   = ram_rnw ? WAIT : WR_BEATS;
          lat_cnt_nx = '0;
          beat_nx    = ram_rnw ? BW'(0) : BW'(1);
        end
      end
      WR_BEATS: begin
        if (last_beat) begin
          state_nx   = WAIT;
          lat_cnt_nx = '0;
          beat_nx    = '0;
        end else begin
          beat_nx = beat + BW'(1);
        end
      end
      WAIT: begin
        if (lat_done) begin
          state_nx   = is_read ? RD_BEATS : WR_ACK;
          lat_cnt_nx = '0;
          beat_nx    = '0;
        end else begin
          lat_cnt_nx = lat_cnt + LW'(1);
        end
      end
      RD_BEATS: begin
        if (last_beat) begin
          state_nx = IDLE;
          beat_nx  = '0;
        end else begin
          beat_nx = beat + BW'(1);
        end
      end
      WR_ACK:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Beat 0 lands with the accept edge; the final beat bypasses wbuf straight into the commit.
  always_ff @(posedge ram_clk) begin
    if (accept)
      wbuf[WORD_SIZE-1:0] <= ram_wdata;
    else if (state == WR_BEATS)
      wbuf[int'(beat)*WORD_SIZE +: WORD_SIZE] <= ram_wdata;
    if (commit) mem[addr_q] <= wline;
  end

  always_comb begin
    wline = wbuf;
    wline[(BEATS-1)*WORD_SIZE +: WORD_SIZE] = ram_wdata;
  end

  always_comb begin
    pattern = '0;
    for (int k = 0; k < BEATS; k++)
      pattern[k*WORD_SIZE +: WORD_SIZE] = WORD_SIZE'(PW'(addr_q) * PW'(BEATS) + PW'(k));
  end

  assign cur_line      = written[addr_q] ? mem[addr_q] : pattern;
  assign data_backdoor = cur_line;
  assign ram_ack       = (state == RD_BEATS) || (state == WR_ACK);
  assign ram_rdata     = (state == RD_BEATS) ? cur_line[int'(beat)*WORD_SIZE +: WORD_SIZE] : '0;

`ifdef RAM_MODEL_CHECK_EN
  always_ff @(posedge ram_clk or negedge ram_rst_n) begin
    if (!ram_rst_n) begin
      proto_err <= 1'b0;
    end else if (ram_avalid && (state != IDLE)) begin
      proto_err <= 1'b1;
      $display("ram_burst_model: ram_avalid ignored outside IDLE at %0t", $time);
    end
  end
`else
  assign proto_err = 1'b0;
`endif
endmodule
